dict_mem_arbiter: RTL and testbench
===================================

DICT_MEM_ARBITER -- requirements
Module: dict_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, dictionary ROM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, dictionary ROM word width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked grants to one requester while the other waits.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have ports a_req  input  1 / b_req  input  1  access request, requester A (processor) / B (scan engine).
REQ-007 SHALL have ports a_addr  input  ADDR_W / b_addr  input  ADDR_W  requested word address.
REQ-008 SHALL have ports a_lock  input  1 / b_lock  input  1  owner requests to keep grant on next cycle.
REQ-009 SHALL have ports a_gnt  output  1 / b_gnt  output  1  access issued this cycle (combinational).
REQ-010 SHALL have ports a_rvalid  output  1 / b_rvalid  output  1  read data valid (registered).
REQ-011 SHALL have ports a_rdata  output  DATA_W / b_rdata  output  DATA_W  read data.
REQ-012 SHALL have port rom_addr  output  ADDR_W  address to synchronous-read dictionary ROM.
REQ-013 SHALL have port rom_data  input  DATA_W  ROM output, valid one cycle after address is presented.
REQ-014 SHALL have port conflict_cnt  output  16  saturating count of cycles a request was denied.

Function
REQ-015 SHALL implement states IDLE, OWN_A, OWN_B (owner of previous cycle's grant), a last_served pointer and a burst counter (0..MAX_BURST).
REQ-016 SHALL assert at most one of a_gnt/b_gnt per cycle; a gnt only when its req is high.
REQ-017 Single requester: SHALL grant it the same cycle, regardless of state.
REQ-018 Both requesting, owner has lock high and burst < MAX_BURST: SHALL grant owner.
REQ-019 Both requesting otherwise (IDLE, owner lock low, or burst == MAX_BURST): SHALL grant the requester not equal to last_served.
REQ-020 Burst counter: SHALL set to 1 on a grant to a new owner, increment (saturating at MAX_BURST) on a grant to the same owner, clear on a cycle with no grant.
REQ-021 Transitions: grant to A -> OWN_A; grant to B -> OWN_B; no grant -> IDLE; last_served updates to the granted requester.
REQ-022 rom_addr SHALL equal the granted requester's addr; 0 when no grant.
REQ-023 x_rvalid SHALL be x_gnt delayed one cycle; x_rdata SHALL equal rom_data when x_rvalid, else 0.
REQ-024 Back-to-back grants alternating A,B SHALL return data in issue order, one word per cycle, no bubbles.
REQ-025 conflict_cnt SHALL increment in each cycle where both req are high; SHALL hold at 16'hFFFF.
REQ-026 lock from a non-owner SHALL be ignored; lock with req low SHALL be ignored.

Reset
REQ-027 On reset low, asynchronously: state IDLE, last_served = B, burst 0, a_rvalid = b_rvalid = 0, conflict_cnt = 0.
REQ-028 While reset low, a_gnt = b_gnt = 0 and rom_addr = 0; an in-flight read SHALL be discarded (no rvalid after release).
REQ-029 First cycle after release with both requesting SHALL grant A.

Verification
REQ-030 Only a_req, a_addr=0x005 -> a_gnt same cycle, rom_addr=0x005, next cycle a_rvalid=1, a_rdata=ROM[5], b_rvalid=0.
REQ-031 a_req,b_req both high 4 cycles, no lock, after reset -> grants A,B,A,B; conflict_cnt=4.
REQ-032 MAX_BURST=8, both requesting, a_lock high 12 cycles -> A granted 8 consecutive cycles, then B, then A again.
REQ-033 b_lock high while A owns, both requesting -> lock ignored, alternation continues.
REQ-034 Assert reset mid-read (cycle after a_gnt) -> a_rvalid stays 0, counters 0; release with both req -> A granted first.
REQ-035 Hold both req 65540 cycles -> conflict_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/dict_mem_arbiter.sv
// Two-requester arbiter in front of a synchronous-read dictionary ROM.
// Requester A is the processor and requester B is the scan engine.
module dict_mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              a_lock,
    input  logic              b_lock,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [15:0]       conflict_cnt
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t             state;
    logic               last_b;
    logic [BURST_W-1:0] burst;
    logic               grant_a;
    logic               grant_b;
    logic               owner_locked;

    // A lock only counts when it comes from the current owner; with a single
    // requester the lock never matters, so a lock with req low is ignored.
    always_comb begin
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        owner_locked = (state == OWN_A && a_lock) || (state == OWN_B && b_lock);
        if (reset) begin
            if (a_req && !b_req) begin
                grant_a = 1'b1;
            end else if (b_req && !a_req) begin
                grant_b = 1'b1;
            end else if (a_req && b_req) begin
                if (owner_locked && burst < BURST_MAX) begin
                    grant_a = (state == OWN_A);
                    grant_b = (state == OWN_B);
                end else if (last_b) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end
        end
    end

    assign a_gnt    = grant_a;
    assign b_gnt    = grant_b;
    assign rom_addr = grant_a ? a_addr : (grant_b ? b_addr : '0);
    assign a_rdata  = a_rvalid ? rom_data : '0;
    assign b_rdata  = b_rvalid ? rom_data : '0;

    // Owner/burst bookkeeping; clearing rvalid on reset drops any in-flight read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_b       <= 1'b1;
            burst        <= '0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            a_rvalid <= grant_a;
            b_rvalid <= grant_b;
            if (a_req && b_req && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (grant_a) begin
                state  <= OWN_A;
                last_b <= 1'b0;
                if (state != OWN_A) begin
                    burst <= BURST_W'(1);
                end else if (burst != BURST_MAX) begin
                    burst <= burst + BURST_W'(1);
                end
            end else if (grant_b) begin
                state  <= OWN_B;
                last_b <= 1'b1;
                if (state != OWN_B) begin
                    burst <= BURST_W'(1);
                end else if (burst != BURST_MAX) begin
                    burst <= burst + BURST_W'(1);
                end
            end else begin
                state <= IDLE;
                burst <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dict_mem_arbiter.sv
// Directed bench for dict_mem_arbiter with a ROM model and a read-data
// scoreboard filled at grant time and drained when rvalid is due.
module tb_dict_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        a_req, b_req;
    logic [11:0] a_addr, b_addr;
    logic        a_lock, b_lock;
    logic        a_gnt, b_gnt;
    logic        a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic [15:0] conflict_cnt;

    typedef struct {
        logic        a_v;
        logic        b_v;
        logic [31:0] data;
    } sb_item_t;

    sb_item_t    sb[$];
    int          checks;
    int          errors;
    logic [15:0] exp_conflict;

    dict_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(8)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .b_req(b_req),
        .a_addr(a_addr), .b_addr(b_addr),
        .a_lock(a_lock), .b_lock(b_lock),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .conflict_cnt(conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {8'hD0, a, ~a};
    endfunction

    always @(posedge clock) rom_data <= rom_word(rom_addr);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: verify the read return owed from the previous cycle, then
    // drive new requests and verify the combinational grant.
    task automatic apply_stimulus(input logic ar, input logic br,
                                  input logic [11:0] aa, input logic [11:0] ba,
                                  input logic al, input logic bl,
                                  input logic eg_a, input logic eg_b);
        sb_item_t e;
        @(negedge clock);
        e = '{a_v: 1'b0, b_v: 1'b0, data: 32'h0};
        if (sb.size() > 0) e = sb.pop_front();
        check_output("a_rvalid", {31'b0, a_rvalid}, {31'b0, e.a_v});
        check_output("b_rvalid", {31'b0, b_rvalid}, {31'b0, e.b_v});
        check_output("a_rdata", a_rdata, e.a_v ? e.data : 32'h0);
        check_output("b_rdata", b_rdata, e.b_v ? e.data : 32'h0);
        check_output("conflict_cnt", {16'b0, conflict_cnt}, {16'b0, exp_conflict});
        a_req = ar; b_req = br; a_addr = aa; b_addr = ba; a_lock = al; b_lock = bl;
        #1;
        check_output("a_gnt", {31'b0, a_gnt}, {31'b0, eg_a});
        check_output("b_gnt", {31'b0, b_gnt}, {31'b0, eg_b});
        check_output("rom_addr", {20'b0, rom_addr}, {20'b0, eg_a ? aa : (eg_b ? ba : 12'h0)});
        if (eg_a || eg_b) sb.push_back('{a_v: eg_a, b_v: eg_b, data: rom_word(eg_a ? aa : ba)});
        if (ar && br && exp_conflict != 16'hFFFF) exp_conflict++;
    endtask

    // Assert reset right away (possibly mid-read) and release it two cycles later.
    task automatic reset_pulse();
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        a_addr = 12'h0; b_addr = 12'h0;
        sb.delete();
        exp_conflict = 16'h0;
        #1;
        check_output("rst_a_gnt", {31'b0, a_gnt}, 32'h0);
        check_output("rst_rom_addr", {20'b0, rom_addr}, 32'h0);
        repeat (2) @(negedge clock);
        check_output("rst_a_rvalid", {31'b0, a_rvalid}, 32'h0);
        check_output("rst_b_rvalid", {31'b0, b_rvalid}, 32'h0);
        check_output("rst_conflict", {16'b0, conflict_cnt}, 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_conflict = 16'h0;
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        a_addr = 12'h0; b_addr = 12'h0;
        reset = 1'b1;
        #2;
        reset_pulse();

        $display("[TB] single requester A");
        apply_stimulus(1, 0, 12'h005, 12'h000, 0, 0, 1, 0);
        apply_stimulus(0, 1, 12'h000, 12'h033, 1, 0, 0, 1);
        apply_stimulus(0, 0, 12'h000, 12'h000, 0, 0, 0, 0);

        $display("[TB] alternation after reset");
        reset_pulse();
        for (int i = 0; i < 4; i++)
            apply_stimulus(1, 1, 12'h010 + 12'(i), 12'h020 + 12'(i), 0, 0, (i % 2) == 0, (i % 2) == 1);
        apply_stimulus(0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
        check_output("conflict_four", {16'b0, conflict_cnt}, 32'd4);

        $display("[TB] burst limit with a_lock");
        reset_pulse();
        for (int i = 0; i < 12; i++)
            apply_stimulus(1, 1, 12'h100 + 12'(i), 12'h200 + 12'(i), 1, 0, i != 8, i == 8);
        apply_stimulus(0, 0, 12'h000, 12'h000, 0, 0, 0, 0);

        $display("[TB] non-owner lock ignored");
        reset_pulse();
        apply_stimulus(1, 1, 12'h0A1, 12'h0B1, 0, 0, 1, 0);
        apply_stimulus(1, 1, 12'h0A2, 12'h0B2, 0, 1, 0, 1);
        apply_stimulus(1, 1, 12'h0A3, 12'h0B3, 0, 0, 1, 0);
        apply_stimulus(1, 1, 12'h0A4, 12'h0B4, 0, 1, 0, 1);
        apply_stimulus(0, 0, 12'h000, 12'h000, 0, 0, 0, 0);

        $display("[TB] reset mid-read");
        reset_pulse();
        apply_stimulus(1, 0, 12'h007, 12'h000, 0, 0, 1, 0);
        reset_pulse();
        apply_stimulus(1, 1, 12'h0C0, 12'h0D0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 12'h000, 12'h000, 0, 0, 0, 0);

        $display("[TB] conflict counter saturation");
        reset_pulse();
        a_req = 1'b1; b_req = 1'b1;
        repeat (65540) @(negedge clock);
        check_output("conflict_sat", {16'b0, conflict_cnt}, 32'h0000FFFF);
        reset_pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
